// File: rtl/prim_fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package prim_fifo_arb_pkg;

    // Arbiter states: IDLE arbitrates each beat, LOCK holds one requester for a packet.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Bits needed to hold values 0..x-1, never less than one bit.
    function automatic int vbits(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/prim_rr_pick.sv
// Round-robin picker: the first set request strictly after ptr, wrapping modulo N.
module prim_rr_pick
    import prim_fifo_arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int IdxW = vbits(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx
);

    // Walk requesters from ptr+1 around to ptr itself; the first valid one wins.
    always_comb begin
        logic found;
        int   k;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IdxW'(k);
            end
        end
    end

endmodule

// File: rtl/prim_fifo_wr_arb.sv
// Packet-aware N:1 write arbiter in front of a FIFO. Single-beat packets are
// arbitrated round-robin; a multi-beat packet locks the grant until its last beat.
module prim_fifo_wr_arb
    import prim_fifo_arb_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int Width   = 16,
    parameter  int Depth   = 4,
    parameter  int MinFree = 1,
    localparam int DepthW  = vbits(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic [N-1:0]         req_valid_i,
    input  logic [N-1:0]         req_last_i,
    input  logic [N*Width-1:0]   req_data_i,
    output logic [N-1:0]         req_ready_o,
    output logic                 fifo_wvalid_o,
    input  logic                 fifo_wready_i,
    output logic [Width-1:0]     fifo_wdata_o,
    input  logic [DepthW-1:0]    fifo_depth_i,
    output logic [N-1:0]         gnt_o,
    output logic                 locked_o
);

    localparam int IdxW = vbits(N);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    arb_state_e      state_q, state_d, state_cur;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d, rr_ptr_cur;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d, lock_idx_cur;

    logic [N-1:0]    pick_gnt;
    logic [IdxW-1:0] pick_idx;
    logic            space_ok;
    logic            gnt_vld;
    logic [IdxW-1:0] gnt_idx;
    logic            xfer;

    // While reset is held the outputs already reflect the values reset will load.
    assign state_cur    = rst_i ? IDLE : state_q;
    assign rr_ptr_cur   = rst_i ? LastIdx : rr_ptr_q;
    assign lock_idx_cur = rst_i ? '0 : lock_idx_q;

    // Signed arithmetic so an over-reported occupancy also blocks new packets.
    assign space_ok = (Depth - int'(fifo_depth_i)) >= MinFree;

    prim_rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req (req_valid_i),
        .ptr (rr_ptr_cur),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Grant selection and the zero-latency mux between requesters and the FIFO.
    always_comb begin
        gnt_vld       = 1'b0;
        gnt_idx       = '0;
        gnt_o         = '0;
        req_ready_o   = '0;
        fifo_wvalid_o = 1'b0;
        fifo_wdata_o  = '0;
        if (state_cur == LOCK) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_idx_cur;
        end else if (space_ok && (|pick_gnt)) begin
            gnt_vld = 1'b1;
            gnt_idx = pick_idx;
        end
        if (gnt_vld) begin
            gnt_o[gnt_idx]       = 1'b1;
            req_ready_o[gnt_idx] = fifo_wready_i;
            fifo_wvalid_o        = req_valid_i[gnt_idx];
            fifo_wdata_o         = req_data_i[gnt_idx*Width +: Width];
        end
    end

    assign xfer     = fifo_wvalid_o & fifo_wready_i;
    assign locked_o = (state_cur == LOCK);

    // Next state: clear wins over a transfer; a last beat releases, a first non-last beat locks.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (clr_i) begin
            state_d  = IDLE;
            rr_ptr_d = LastIdx;
        end else if (xfer) begin
            if (req_last_i[gnt_idx]) begin
                state_d  = IDLE;
                rr_ptr_d = gnt_idx;
            end else if (state_q == IDLE) begin
                state_d    = LOCK;
                lock_idx_d = gnt_idx;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= LastIdx;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule
